output_port_arbiter: RTL and testbench

//  Downstream neighbour of the router input port: one instance per router output direction.

---
 rtl/output_port_arbiter_pkg.sv | 17 +
 rtl/output_port_arbiter_rr_arbiter.sv | 49 ++++
 rtl/output_port_arbiter.sv | 99 +++++++++
 tb/tb_output_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Shared router definitions: port indices, packet geometry and the output-port FSM encoding.
package output_port_arbiter_pkg;
    localparam int EAST         = 0;
    localparam int NORTH        = 1;
    localparam int WEST         = 2;
    localparam int SOUTH        = 3;
    localparam int LOCAL        = 4;
    localparam int NUM_PORTS    = 5;
    localparam int DATA_WIDTH   = 32;
    localparam int PACKET_WIDTH = 55;
    localparam int CNT_WIDTH    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts at pointer p, first requester wins, p moves past the winner.
module output_port_arbiter_rr_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int N = NUM_PORTS
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         any
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = N'(1);

    logic [PW-1:0]  r_ptr;
    logic [2*N-1:0] w_rot_dbl;
    logic [2*N-1:0] w_back_dbl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_iso;
    logic [PW-1:0]  w_winner;

    // Rotate so bit 0 is the pointer position, isolate the lowest set bit, rotate back.
    assign w_rot_dbl  = {req, req} >> r_ptr;
    assign w_rot      = w_rot_dbl[N-1:0];
    assign w_iso      = w_rot & (~w_rot + ONE);
    assign w_back_dbl = {w_iso, w_iso} << r_ptr;
    assign grant      = w_back_dbl[2*N-1:N];
    assign any        = |req;

    always_comb begin
        w_winner = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                w_winner = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && any) begin
            r_ptr <= (w_winner == PW'(N - 1)) ? '0 : w_winner + PW'(1);
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// Output-direction arbiter: picks one input controller round-robin, holds its packet in a
// single output register and hands it downstream over a req/gnt handshake.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int packetwidth = output_port_arbiter_pkg::PACKET_WIDTH,
    parameter int NUM_PORTS   = output_port_arbiter_pkg::NUM_PORTS,
    parameter int cntWidth    = output_port_arbiter_pkg::CNT_WIDTH
)
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             reqIn,
    input  logic [NUM_PORTS*packetwidth-1:0] PacketIn,
    output logic [NUM_PORTS-1:0]             gntIn,
    output logic                             reqDnStr,
    input  logic                             gntDnStr,
    output logic [packetwidth-1:0]           PacketOut,
    output logic [cntWidth-1:0]              pktCount
);
    state_t                 r_state;
    logic                   r_req_dn;
    logic [packetwidth-1:0] r_pkt;
    logic [cntWidth-1:0]    r_cnt;

    logic                   w_xfer;
    logic                   w_load;
    logic                   w_any;
    logic [NUM_PORTS-1:0]   w_grant;
    logic [packetwidth-1:0] w_sel;
    logic [packetwidth-1:0] w_masked [NUM_PORTS];

    assign w_xfer = r_req_dn & gntDnStr;
    // A new packet may only be taken when the output register is empty or draining this cycle.
    assign w_load = ((r_state == IDLE) | w_xfer) & w_any & ~reset;
    assign gntIn  = {NUM_PORTS{w_load}} & w_grant;

    output_port_arbiter_rr_arbiter #(
        .N       (NUM_PORTS)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (reqIn),
        .advance (w_load),
        .grant   (w_grant),
        .any     (w_any)
    );

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
        assign w_masked[gi] = PacketIn[gi*packetwidth +: packetwidth] & {packetwidth{w_grant[gi]}};
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_sel = w_sel | w_masked[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_req_dn <= 1'b0;
            r_pkt    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_xfer) begin
                r_cnt <= r_cnt + cntWidth'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_pkt    <= w_sel;
                        r_req_dn <= 1'b1;
                        r_state  <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (w_load) begin
                            r_pkt <= w_sel;
                        end else begin
                            r_req_dn <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: begin
                    r_req_dn <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign reqDnStr  = r_req_dn;
    assign PacketOut = r_pkt;
    assign pktCount  = r_cnt;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model with a delivery-order scoreboard.
module tb_output_port_arbiter;
    localparam int NP = 5;
    localparam int PW = 55;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP-1:0]    reqIn = '0;
    logic [NP*PW-1:0] PacketIn = '0;
    logic             gntDnStr = 1'b0;
    logic [NP-1:0]    gntIn;
    logic             reqDnStr;
    logic [PW-1:0]    PacketOut;
    logic [CW-1:0]    pktCount;

    always #5 clk = ~clk;

    output_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .reqIn     (reqIn),
        .PacketIn  (PacketIn),
        .gntIn     (gntIn),
        .reqDnStr  (reqDnStr),
        .gntDnStr  (gntDnStr),
        .PacketOut (PacketOut),
        .pktCount  (pktCount)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int            m_p = 0;
    bit            m_valid = 1'b0;
    logic [PW-1:0] m_pkt = '0;
    int            m_cnt = 0;
    logic [PW-1:0] sb_q[$];
    int            sb_errs = 0;
    bit            verbose = 1'b1;

    logic [NP-1:0] obs_gnt, exp_gnt;
    logic          obs_req, exp_req;
    logic [PW-1:0] obs_pkt, exp_pkt;
    logic [CW-1:0] obs_cnt, exp_cnt;

    function automatic logic [PW-1:0] slice(int i);
        return PacketIn[i*PW +: PW];
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    // One clock: sample DUT at negedge, compute expectations, advance the model.
    task automatic step();
        int  w;
        bit  xfer;
        bit  load;
        @(negedge clk);
        obs_gnt = gntIn;
        obs_req = reqDnStr;
        obs_pkt = PacketOut;
        obs_cnt = pktCount;
        exp_req = m_valid;
        exp_pkt = m_pkt;
        exp_cnt = CW'(m_cnt);
        xfer = m_valid && gntDnStr && !reset;
        w = -1;
        if (!reset && (!m_valid || xfer)) begin
            for (int k = 0; k < NP; k++) begin
                if (w < 0 && reqIn[(m_p + k) % NP]) w = (m_p + k) % NP;
            end
        end
        load = (w >= 0);
        exp_gnt = '0;
        if (load) exp_gnt[w] = 1'b1;
        if (reset) begin
            m_p = 0; m_valid = 1'b0; m_pkt = '0; m_cnt = 0;
            sb_q.delete();
        end else begin
            if (xfer) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (sb_q.size() == 0 || sb_q[0] !== obs_pkt) sb_errs++;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                if (verbose) $display("xfer %0d: PacketOut=%h pktCount->%0d", m_cnt, obs_pkt, m_cnt);
            end
            if (load) begin
                m_pkt = slice(w);
                m_valid = 1'b1;
                m_p = (w + 1) % NP;
                sb_q.push_back(slice(w));
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reqIn = '0;
        gntDnStr = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        n_vec++;
        if ({obs_gnt, obs_req, obs_pkt, obs_cnt} !== {NP'(0), 1'b0, PW'(0), CW'(0)}) begin
            n_err++;
            $display("FAIL reset_state: got gnt=%b req=%b pkt=%h cnt=%h, expected all zero", obs_gnt, obs_req, obs_pkt, obs_cnt);
        end
    endtask

    task automatic test_single();
        reqIn = 5'b00001;
        PacketIn[0 +: PW] = 55'h1234;
        gntDnStr = 1'b1;
        step();
        n_vec++;
        if (obs_gnt !== 5'b00001 || obs_gnt !== exp_gnt) begin
            n_err++;
            $display("FAIL single_grant: got gnt=%b expected %b", obs_gnt, 5'b00001);
        end
        reqIn = '0;
        step();
        n_vec++;
        if ({obs_req, obs_pkt, obs_cnt} !== {1'b1, PW'(55'h1234), CW'(0)}) begin
            n_err++;
            $display("FAIL single_out: got req=%b pkt=%h cnt=%h expected req=1 pkt=1234 cnt=0", obs_req, obs_pkt, obs_cnt);
        end
        step();
        n_vec++;
        if (obs_cnt !== 16'd1 || obs_req !== 1'b0 || {obs_gnt, obs_pkt} !== {exp_gnt, exp_pkt}) begin
            n_err++;
            $display("FAIL single_count: got cnt=%h req=%b pkt=%h expected cnt=1 req=0 pkt=%h", obs_cnt, obs_req, obs_pkt, exp_pkt);
        end
    endtask

    task automatic test_rotation();
        logic [NP-1:0] seq [6];
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        do_reset();
        reqIn = '1;
        for (int i = 0; i < NP; i++) PacketIn[i*PW +: PW] = rand_pkt();
        gntDnStr = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_vec++;
            if (obs_gnt !== seq[c] || {obs_req, obs_pkt, obs_cnt} !== {exp_req, exp_pkt, exp_cnt}) begin
                n_err++;
                $display("FAIL rotation[%0d]: got gnt=%b req=%b pkt=%h cnt=%h expected gnt=%b req=%b pkt=%h cnt=%h",
                         c, obs_gnt, obs_req, obs_pkt, obs_cnt, seq[c], exp_req, exp_pkt, exp_cnt);
            end
            for (int i = 0; i < NP; i++) if (obs_gnt[i]) PacketIn[i*PW +: PW] = rand_pkt();
        end
        step();
        n_vec++;
        if (obs_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL rotation_count: got pktCount=%0d expected 5", obs_cnt);
        end
        reqIn = '0;
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] held;
        do_reset();
        reqIn = 5'b00001;
        held = rand_pkt();
        PacketIn[0 +: PW] = held;
        step();
        reqIn = 5'b00010;
        PacketIn[PW +: PW] = rand_pkt();
        for (int c = 0; c < 10; c++) begin
            step();
            n_vec++;
            if ({obs_gnt, obs_req, obs_pkt, obs_cnt} !== {NP'(0), 1'b1, held, CW'(0)}) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got gnt=%b req=%b pkt=%h cnt=%h expected gnt=0 req=1 pkt=%h cnt=0",
                         c, obs_gnt, obs_req, obs_pkt, obs_cnt, held);
            end
        end
        gntDnStr = 1'b1;
        step();
        n_vec++;
        if (obs_gnt !== 5'b00010 || obs_pkt !== held) begin
            n_err++;
            $display("FAIL backpressure_release: got gnt=%b pkt=%h expected gnt=00010 pkt=%h", obs_gnt, obs_pkt, held);
        end
        reqIn = '0;
        step();
        n_vec++;
        if ({obs_cnt, obs_pkt} !== {CW'(1), slice(1)}) begin
            n_err++;
            $display("FAIL backpressure_next: got cnt=%h pkt=%h expected cnt=1 pkt=%h", obs_cnt, obs_pkt, slice(1));
        end
    endtask

    task automatic test_pointer();
        do_reset();
        reqIn = 5'b00100;
        PacketIn[2*PW +: PW] = rand_pkt();
        gntDnStr = 1'b1;
        step();
        reqIn = 5'b10100;
        PacketIn[2*PW +: PW] = rand_pkt();
        PacketIn[4*PW +: PW] = rand_pkt();
        step();
        n_vec++;
        if (obs_gnt !== 5'b10000 || obs_gnt !== exp_gnt) begin
            n_err++;
            $display("FAIL pointer_p3: got gnt=%b expected 10000", obs_gnt);
        end
        reqIn = 5'b00100;
        step();
        n_vec++;
        if (obs_gnt !== 5'b00100 || {obs_req, obs_pkt} !== {exp_req, exp_pkt}) begin
            n_err++;
            $display("FAIL pointer_wrap: got gnt=%b pkt=%h expected gnt=00100 pkt=%h", obs_gnt, obs_pkt, exp_pkt);
        end
        reqIn = '0;
        step();
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        reqIn = 5'b00001;
        PacketIn[0 +: PW] = rand_pkt();
        gntDnStr = 1'b1;
        step();
        reqIn = 5'b01000;
        PacketIn[3*PW +: PW] = rand_pkt();
        step();
        PacketIn[3*PW +: PW] = rand_pkt();
        gntDnStr = 1'b0;
        step();
        n_vec++;
        if ({obs_req, obs_cnt, obs_gnt} !== {1'b1, CW'(1), NP'(0)}) begin
            n_err++;
            $display("FAIL midsend_hold: got req=%b cnt=%h gnt=%b expected req=1 cnt=1 gnt=0", obs_req, obs_cnt, obs_gnt);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        n_vec++;
        if ({obs_req, obs_pkt, obs_cnt, obs_gnt} !== {1'b0, PW'(0), CW'(0), NP'(5'b01000)}) begin
            n_err++;
            $display("FAIL midsend_reset: got req=%b pkt=%h cnt=%h gnt=%b expected req=0 pkt=0 cnt=0 gnt=01000",
                     obs_req, obs_pkt, obs_cnt, obs_gnt);
        end
        reqIn = '0;
        step();
    endtask

    task automatic test_random();
        do_reset();
        sb_errs = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            n_vec++;
            if ({obs_gnt, obs_req, obs_pkt, obs_cnt} !== {exp_gnt, exp_req, exp_pkt, exp_cnt}) begin
                n_err++;
                $display("FAIL random[%0d]: got gnt=%b req=%b pkt=%h cnt=%h expected gnt=%b req=%b pkt=%h cnt=%h",
                         c, obs_gnt, obs_req, obs_pkt, obs_cnt, exp_gnt, exp_req, exp_pkt, exp_cnt);
            end
            // Controllers hold until granted, then drop or refresh.
            for (int i = 0; i < NP; i++) begin
                if (reqIn[i] && !obs_gnt[i]) continue;
                if ($urandom_range(99) < 50) begin
                    reqIn[i] = 1'b1;
                    PacketIn[i*PW +: PW] = rand_pkt();
                end else begin
                    reqIn[i] = 1'b0;
                end
            end
            gntDnStr = ($urandom_range(99) < 70);
        end
        reqIn = '0;
        gntDnStr = 1'b1;
        for (int c = 0; c < 3; c++) step();
        n_vec++;
        if (sb_errs !== 0 || sb_q.size() !== 0) begin
            n_err++;
            $display("FAIL random_scoreboard: got %0d order errors, %0d undelivered, expected 0 and 0", sb_errs, sb_q.size());
        end
    endtask

    task automatic test_wrap();
        bit done;
        do_reset();
        sb_errs = 0;
        verbose = 1'b0;
        reqIn = '1;
        for (int i = 0; i < NP; i++) PacketIn[i*PW +: PW] = rand_pkt();
        gntDnStr = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 70000 && !done; c++) begin
            step();
            n_vec++;
            if ({obs_gnt, obs_req, obs_pkt, obs_cnt} !== {exp_gnt, exp_req, exp_pkt, exp_cnt}) begin
                n_err++;
                $display("FAIL wrap_run[%0d]: got gnt=%b req=%b pkt=%h cnt=%h expected gnt=%b req=%b pkt=%h cnt=%h",
                         c, obs_gnt, obs_req, obs_pkt, obs_cnt, exp_gnt, exp_req, exp_pkt, exp_cnt);
            end
            if (obs_cnt === 16'hFFFF) done = 1'b1;
            for (int i = 0; i < NP; i++) if (obs_gnt[i]) PacketIn[i*PW +: PW] = rand_pkt();
        end
        verbose = 1'b1;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL wrap_timeout: pktCount=%h never reached ffff within budget", obs_cnt);
        end
        step();
        n_vec++;
        if (obs_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap: got pktCount=%h expected 0000", obs_cnt);
        end
        n_vec++;
        if (sb_errs !== 0) begin
            n_err++;
            $display("FAIL wrap_scoreboard: got %0d order errors expected 0", sb_errs);
        end
        reqIn = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_pointer();
        test_reset_mid_send();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
